mod_split: RTL and testbench

- Stream distributor that fans one WIDTH-bit valid/ready input stream out to two output lanes, y1 and y2.
- It is the inverse of the two-input combining tree: one stream in, two consumers out (e.g. two mod_and leaf operands).
- Each lane has its own DEPTH-entry FIFO, so a stalled consumer does not block the other lane until that lane's FIFO fills.
- Two distribution modes: alternate (round-robin) and broadcast (both lanes).

---
 rtl/mod_split_if.sv | 37 +++
 rtl/mod_split.sv | 104 ++++++++++
 tb/tb_mod_split.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mod_split_if.sv
// mod_split_if: stream bundle between a producer/consumer pair and mod_split.
//
// Signals:
//   mode               0 = alternate lanes, 1 = broadcast to both lanes
//   in_valid/in_ready  input stream handshake, in_data is the payload
//   y1_valid/y1_ready  lane 1 output handshake, y1_data is the lane 1 FIFO head
//   y2_valid/y2_ready  lane 2 output handshake, y2_data is the lane 2 FIFO head
//   lane_sel           lane that the next alternate-mode beat goes to (0 = y1)
//
// Modports:
//   master  the environment: drives the input stream and the lane readies
//   slave   the splitter itself
interface mod_split_if #(
    parameter int WIDTH = 8
);
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             y1_valid;
    logic             y1_ready;
    logic [WIDTH-1:0] y1_data;
    logic             y2_valid;
    logic             y2_ready;
    logic [WIDTH-1:0] y2_data;
    logic             lane_sel;

    modport master (
        output mode, in_valid, in_data, y1_ready, y2_ready,
        input  in_ready, y1_valid, y1_data, y2_valid, y2_data, lane_sel
    );

    modport slave (
        input  mode, in_valid, in_data, y1_ready, y2_ready,
        output in_ready, y1_valid, y1_data, y2_valid, y2_data, lane_sel
    );
endinterface

// File: rtl/mod_split.sv
// mod_split: distributes one valid/ready stream over two output lanes.
//
// Each lane owns a DEPTH-entry FIFO so a stalled consumer only holds up the
// input once its own lane is full. In alternate mode beats go round-robin,
// starting with y1; in broadcast mode each beat is written to both lanes.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   mod_split_if slave modport (input stream, two lane outputs,
//         mode select and the lane_sel status)
//
// Parameters:
//   WIDTH  payload width, must match the interface WIDTH
//   DEPTH  entries per lane FIFO, power of two and at least 2
module mod_split #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    mod_split_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem  [2][DEPTH];
    logic [PW-1:0]    wptr [2];
    logic [PW-1:0]    rptr [2];
    logic [CW-1:0]    cnt  [2];
    logic             lane_sel_q;

    logic [1:0] full;
    logic [1:0] valid;
    logic [1:0] push;
    logic [1:0] pop;
    logic       ready;
    logic       accept;

    // in_ready looks only at registered occupancy, lane_sel and mode. A full
    // lane refuses a push even when it is being popped in the same cycle, so
    // the input side never depends on the lane readies.
    always_comb begin
        full[0]  = (cnt[0] == FULL_CNT);
        full[1]  = (cnt[1] == FULL_CNT);
        valid[0] = (cnt[0] != '0);
        valid[1] = (cnt[1] != '0);

        if (bus.mode)
            ready = !full[0] && !full[1];
        else
            ready = lane_sel_q ? !full[1] : !full[0];
        ready = ready && !rst;

        accept  = bus.in_valid && ready;
        push[0] = accept && (bus.mode || !lane_sel_q);
        push[1] = accept && (bus.mode ||  lane_sel_q);
        pop[0]  = valid[0] && bus.y1_ready;
        pop[1]  = valid[1] && bus.y2_ready;
    end

    assign bus.in_ready = ready;
    assign bus.y1_valid = valid[0];
    assign bus.y2_valid = valid[1];
    assign bus.y1_data  = mem[0][rptr[0]];
    assign bus.y2_data  = mem[1][rptr[1]];
    assign bus.lane_sel = lane_sel_q;

    // Both lane FIFOs. Storage is cleared on reset so the data outputs read
    // zero while the lanes are empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < 2; l++) begin
                for (int e = 0; e < DEPTH; e++)
                    mem[l][e] <= '0;
                wptr[l] <= '0;
                rptr[l] <= '0;
                cnt[l]  <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (push[l]) begin
                    mem[l][wptr[l]] <= bus.in_data;
                    wptr[l]         <= wptr[l] + PW'(1);
                end
                if (pop[l])
                    rptr[l] <= rptr[l] + PW'(1);
                if (push[l] && !pop[l])
                    cnt[l] <= cnt[l] + CW'(1);
                else if (!push[l] && pop[l])
                    cnt[l] <= cnt[l] - CW'(1);
            end
        end
    end

    // Round-robin pointer; broadcast beats leave it where it is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lane_sel_q <= 1'b0;
        else if (accept && !bus.mode)
            lane_sel_q <= !lane_sel_q;
    end
endmodule

// File: tb/tb_mod_split.sv
// tb_mod_split: directed self-checking bench for mod_split (WIDTH=8, DEPTH=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_mod_split;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mod_split_if #(.WIDTH(8)) bus ();

    mod_split #(.WIDTH(8), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] alt_data   [4];
    logic [3:0] alt_dest;
    logic [3:0] alt_sel_after;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse rst fully between two rising edges.
    task automatic pulse_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #4 rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #2;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        total++; if (bus.y1_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_y1_valid: got %b expected 0", bus.y1_valid); end
        total++; if (bus.y2_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_y2_valid: got %b expected 0", bus.y2_valid); end
        total++; if (bus.y1_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_y1_data: got %h expected 00", bus.y1_data); end
        total++; if (bus.y2_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_y2_data: got %h expected 00", bus.y2_data); end
        total++; if (bus.lane_sel !== 1'b0) begin bad++; $display("[TB] FAIL reset_lane_sel: got %b expected 0", bus.lane_sel); end
        step();
        step();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_held_in_ready: got %b expected 0", bus.in_ready); end
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready: got %b expected 1", bus.in_ready); end
        step();
    endtask

    task automatic test_alternate();
        alt_data[0] = 8'h11; alt_data[1] = 8'h22; alt_data[2] = 8'h33; alt_data[3] = 8'h44;
        alt_dest      = 4'b1010;
        alt_sel_after = 4'b0101;
        bus.mode = 1'b0; bus.y1_ready = 1'b1; bus.y2_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = alt_data[i];
            #1;
            total++; if (bus.lane_sel !== alt_dest[i]) begin bad++; $display("[TB] FAIL alt_sel_before[%0d]: got %b expected %b", i, bus.lane_sel, alt_dest[i]); end
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL alt_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
            if (i == 0) begin
                total++; if (bus.y1_valid !== 1'b0) begin bad++; $display("[TB] FAIL alt_no_bypass: got %b expected 0", bus.y1_valid); end
            end
            step();
            if (alt_dest[i] == 1'b0) begin
                total++; if (bus.y1_valid !== 1'b1 || bus.y1_data !== alt_data[i]) begin bad++; $display("[TB] FAIL alt_y1[%0d]: got v=%b d=%h expected v=1 d=%h", i, bus.y1_valid, bus.y1_data, alt_data[i]); end
                total++; if (bus.y2_valid !== 1'b0) begin bad++; $display("[TB] FAIL alt_y2_idle[%0d]: got %b expected 0", i, bus.y2_valid); end
            end else begin
                total++; if (bus.y2_valid !== 1'b1 || bus.y2_data !== alt_data[i]) begin bad++; $display("[TB] FAIL alt_y2[%0d]: got v=%b d=%h expected v=1 d=%h", i, bus.y2_valid, bus.y2_data, alt_data[i]); end
                total++; if (bus.y1_valid !== 1'b0) begin bad++; $display("[TB] FAIL alt_y1_idle[%0d]: got %b expected 0", i, bus.y1_valid); end
            end
            total++; if (bus.lane_sel !== alt_sel_after[i]) begin bad++; $display("[TB] FAIL alt_sel_after[%0d]: got %b expected %b", i, bus.lane_sel, alt_sel_after[i]); end
        end
        bus.in_valid = 1'b0;
        step();
        total++; if (bus.y1_valid !== 1'b0 || bus.y2_valid !== 1'b0) begin bad++; $display("[TB] FAIL alt_drained: got y1=%b y2=%b expected 0 0", bus.y1_valid, bus.y2_valid); end
        total++; if (bus.lane_sel !== 1'b0) begin bad++; $display("[TB] FAIL alt_sel_end: got %b expected 0", bus.lane_sel); end
    endtask

    task automatic test_broadcast();
        bus.mode = 1'b1; bus.y1_ready = 1'b1; bus.y2_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'hA5;
        step();
        total++; if (bus.y1_valid !== 1'b1 || bus.y1_data !== 8'hA5) begin bad++; $display("[TB] FAIL bc_y1_first: got v=%b d=%h expected v=1 d=a5", bus.y1_valid, bus.y1_data); end
        total++; if (bus.y2_valid !== 1'b1 || bus.y2_data !== 8'hA5) begin bad++; $display("[TB] FAIL bc_y2_first: got v=%b d=%h expected v=1 d=a5", bus.y2_valid, bus.y2_data); end
        bus.in_data = 8'h5A;
        step();
        total++; if (bus.y1_valid !== 1'b1 || bus.y1_data !== 8'h5A) begin bad++; $display("[TB] FAIL bc_y1_second: got v=%b d=%h expected v=1 d=5a", bus.y1_valid, bus.y1_data); end
        total++; if (bus.y2_valid !== 1'b1 || bus.y2_data !== 8'h5A) begin bad++; $display("[TB] FAIL bc_y2_second: got v=%b d=%h expected v=1 d=5a", bus.y2_valid, bus.y2_data); end
        total++; if (bus.lane_sel !== 1'b0) begin bad++; $display("[TB] FAIL bc_lane_sel: got %b expected 0", bus.lane_sel); end
        bus.in_valid = 1'b0;
        step();
        total++; if (bus.y1_valid !== 1'b0 || bus.y2_valid !== 1'b0) begin bad++; $display("[TB] FAIL bc_drained: got y1=%b y2=%b expected 0 0", bus.y1_valid, bus.y2_valid); end
    endtask

    task automatic test_lane_stall();
        bus.mode = 1'b0; bus.y1_ready = 1'b0; bus.y2_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_data = 8'(i);
            step();
        end
        bus.in_data = 8'h05;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready: got %b expected 0", bus.in_ready); end
        total++; if (bus.y1_data !== 8'h01) begin bad++; $display("[TB] FAIL stall_y1_head: got %h expected 01", bus.y1_data); end
        total++; if (bus.y2_valid !== 1'b1 || bus.y2_data !== 8'h04) begin bad++; $display("[TB] FAIL stall_y2_head: got v=%b d=%h expected v=1 d=04", bus.y2_valid, bus.y2_data); end
        step();
        total++; if (bus.y2_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_y2_drained: got %b expected 0", bus.y2_valid); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_still_blocked: got %b expected 0", bus.in_ready); end
        bus.y1_ready = 1'b1;
        step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_release_ready: got %b expected 1", bus.in_ready); end
        total++; if (bus.y1_data !== 8'h03) begin bad++; $display("[TB] FAIL stall_after_pop: got %h expected 03", bus.y1_data); end
        step();
        total++; if (bus.y1_valid !== 1'b1 || bus.y1_data !== 8'h05) begin bad++; $display("[TB] FAIL stall_beat5: got v=%b d=%h expected v=1 d=05", bus.y1_valid, bus.y1_data); end
        total++; if (bus.lane_sel !== 1'b1) begin bad++; $display("[TB] FAIL stall_lane_sel: got %b expected 1", bus.lane_sel); end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_full_pop();
        pulse_reset();
        bus.mode = 1'b0; bus.y1_ready = 1'b0; bus.y2_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_data = 8'(i);
            step();
        end
        bus.in_data = 8'h55;
        bus.y1_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fullpop_blocked: got %b expected 0", bus.in_ready); end
        step();
        bus.y1_ready = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.y1_valid !== 1'b1 || bus.y1_data !== 8'h03) begin bad++; $display("[TB] FAIL fullpop_no_accept: got v=%b d=%h expected v=1 d=03", bus.y1_valid, bus.y1_data); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL fullpop_ready_next: got %b expected 1", bus.in_ready); end
        total++; if (bus.lane_sel !== 1'b0) begin bad++; $display("[TB] FAIL fullpop_lane_sel: got %b expected 0", bus.lane_sel); end
        // One more push fills y1 again only if its occupancy really was 1.
        bus.in_valid = 1'b1; bus.in_data = 8'h66;
        step();
        bus.in_valid = 1'b0;
        bus.y2_ready = 1'b0;
        step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL fullpop_y2_room: got %b expected 1", bus.in_ready); end
        bus.mode = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fullpop_y1_refilled: got %b expected 0", bus.in_ready); end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        bus.y1_ready = 1'b0; bus.y2_ready = 1'b0;
        bus.mode = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h66;
        step();
        bus.mode = 1'b1; bus.in_data = 8'h77;
        step();
        bus.mode = 1'b0; bus.in_data = 8'h88;
        step();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.y1_data !== 8'h66 || bus.y2_data !== 8'h77) begin bad++; $display("[TB] FAIL mid_loaded: got y1=%h y2=%h expected 66 77", bus.y1_data, bus.y2_data); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_full: got %b expected 0", bus.in_ready); end
        #1 rst = 1'b1;
        #1;
        total++; if (bus.y1_valid !== 1'b0 || bus.y2_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid_clear: got y1=%b y2=%b expected 0 0", bus.y1_valid, bus.y2_valid); end
        total++; if (bus.y1_data !== 8'h00 || bus.y2_data !== 8'h00) begin bad++; $display("[TB] FAIL mid_data_clear: got y1=%h y2=%h expected 00 00", bus.y1_data, bus.y2_data); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_in_ready_rst: got %b expected 0", bus.in_ready); end
        #2 rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1 || bus.lane_sel !== 1'b0) begin bad++; $display("[TB] FAIL mid_release: got ready=%b sel=%b expected 1 0", bus.in_ready, bus.lane_sel); end
        step();
        total++; if (bus.y1_valid !== 1'b0 || bus.y2_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_stays_empty: got y1=%b y2=%b expected 0 0", bus.y1_valid, bus.y2_valid); end
    endtask

    task automatic test_mode_switch();
        pulse_reset();
        bus.y1_ready = 1'b0; bus.y2_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.mode = 1'b0; bus.in_data = 8'h10;
        step();
        bus.mode = 1'b1; bus.in_data = 8'h20;
        step();
        bus.mode = 1'b0; bus.in_data = 8'h30;
        step();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.y1_data !== 8'h10 || bus.y2_data !== 8'h20) begin bad++; $display("[TB] FAIL ms_heads: got y1=%h y2=%h expected 10 20", bus.y1_data, bus.y2_data); end
        total++; if (bus.lane_sel !== 1'b0) begin bad++; $display("[TB] FAIL ms_lane_sel: got %b expected 0", bus.lane_sel); end
        bus.y1_ready = 1'b1; bus.y2_ready = 1'b1;
        step();
        total++; if (bus.y1_data !== 8'h20 || bus.y2_data !== 8'h30) begin bad++; $display("[TB] FAIL ms_tails: got y1=%h y2=%h expected 20 30", bus.y1_data, bus.y2_data); end
        step();
        total++; if (bus.y1_valid !== 1'b0 || bus.y2_valid !== 1'b0) begin bad++; $display("[TB] FAIL ms_drained: got y1=%b y2=%b expected 0 0", bus.y1_valid, bus.y2_valid); end
    endtask

    // Test sequence.
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.mode     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.y1_ready = 1'b0;
        bus.y2_ready = 1'b0;
        test_reset();
        test_alternate();
        test_broadcast();
        test_lane_stall();
        test_full_pop();
        test_reset_mid();
        test_mode_switch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
